// File: rtl/uart_rx_ctrl_if.sv
// Serial-receive bundle between the rx pad, the receive sequencer and the RX FIFO/CPU register.
// The receiver uses the slave modport; whatever drives the line uses the master modport.
interface uart_rx_ctrl_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        output busy
    );

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit sampling, LSB-first byte capture, stop/parity check.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_ctrl_if.slave  io_bus
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_parity_error;
    logic             r_framing_error;
    logic             w_bit_tick;
    logic             w_half_tick;
    logic             w_shift;
    logic             w_load;
    logic             w_par_err;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
    logic             w_par_latch;
`endif

    assign w_bit_tick  = (r_cnt == LP_CNT_LAST);
    assign w_half_tick = (r_cnt == LP_CNT_HALF);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_shift     = 1'b0;
        w_load      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_latch = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Re-check the line at half a bit so every later tick lands mid-bit.
                if (w_half_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_cnt_nxt = '0;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_par_latch = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Parity comparator only matters on the frame-completion strobe.
`ifdef UART_RX_PARITY_EN
    assign w_par_err = w_load & (r_par_bit ^ (^r_shreg));
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta       <= 1'b1;
            r_rx_s          <= 1'b1;
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_rx_meta  <= io_bus.rx;
            r_rx_s     <= r_rx_meta;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rx_valid <= w_load;
            if (r_state == S_IDLE) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
            end
            // Outputs register on the stop-bit tick, so rx_valid is high during DONE.
            if (w_load) begin
                r_rx_data       <= r_shreg;
                r_parity_error  <= w_par_err;
                r_framing_error <= ~r_rx_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_shreg[r_bit_idx] <= r_rx_s;
        end
`ifdef UART_RX_PARITY_EN
        if (w_par_latch) begin
            r_par_bit <= r_rx_s;
        end
`endif
    end

    assign io_bus.rx_data       = r_rx_data;
    assign io_bus.rx_valid      = r_rx_valid;
    assign io_bus.parity_error  = r_parity_error;
    assign io_bus.framing_error = r_framing_error;
    assign io_bus.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 8 clocks per bit; adapts frame length to UART_RX_PARITY_EN.
module tb_uart_rx_ctrl;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_ON     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_ON     = 1'b0;
`endif
    localparam int LAT = 6 + CPB * (FRAME_BITS - 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int pcyc   = 0;
    int vcount = 0;
    logic [7:0] v_data [0:63];
    logic       v_pe   [0:63];
    logic       v_fe   [0:63];
    int         v_cyc  [0:63];

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            if (vcount < 64) begin
                v_data[vcount] <= bus.rx_data;
                v_pe[vcount]   <= bus.parity_error;
                v_fe[vcount]   <= bus.framing_error;
                v_cyc[vcount]  <= pcyc;
            end
            vcount <= vcount + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", pcyc);
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) begin
            send_bit((i == FRAME_BITS - 1) ? stop : f[i]);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.rx_valid); end
        checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL rst_pe got %b exp 0", bus.parity_error); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL rst_fe got %b exp 0", bus.framing_error); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        idle(4);
    endtask

    task automatic test_basic();
        int n0, s, lat;
        n0 = vcount;
        s  = pcyc;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(2 * CPB);
        lat = v_cyc[n0] - s;
        checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL basic_count got %0d exp %0d", vcount - n0, 1); end
        checks++; if (v_data[n0] !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", v_data[n0]); end
        checks++; if (v_pe[n0] !== 1'b0) begin errors++; $display("FAIL basic_pe got %b exp 0", v_pe[n0]); end
        checks++; if (v_fe[n0] !== 1'b0) begin errors++; $display("FAIL basic_fe got %b exp 0", v_fe[n0]); end
        checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d+-1", lat, LAT); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_parity();
        int n0;
        n0 = vcount;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(2 * CPB);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * CPB);
        checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL par_count got %0d exp 2", vcount - n0); end
        checks++; if (v_data[n0] !== 8'h07) begin errors++; $display("FAIL par_data got %h exp 07", v_data[n0]); end
        checks++; if (v_pe[n0] !== PAR_ON) begin errors++; $display("FAIL par_bad_pe got %b exp %b", v_pe[n0], PAR_ON); end
        checks++; if (v_fe[n0] !== 1'b0) begin errors++; $display("FAIL par_bad_fe got %b exp 0", v_fe[n0]); end
        checks++; if (v_data[n0+1] !== 8'h07) begin errors++; $display("FAIL par_good_data got %h exp 07", v_data[n0+1]); end
        checks++; if (v_pe[n0+1] !== 1'b0) begin errors++; $display("FAIL par_good_pe got %b exp 0", v_pe[n0+1]); end
    endtask

    task automatic test_framing();
        int n0;
        n0 = vcount;
        send_frame(8'hA3, 1'b0, 1'b0);
        idle(2 * CPB);
        checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL frm_count got %0d exp 1", vcount - n0); end
        checks++; if (v_data[n0] !== 8'hA3) begin errors++; $display("FAIL frm_data got %h exp a3", v_data[n0]); end
        checks++; if (v_fe[n0] !== 1'b1) begin errors++; $display("FAIL frm_fe got %b exp 1", v_fe[n0]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL frm_busy got %b exp 0", bus.busy); end
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL frm_next_count got %0d exp 2", vcount - n0); end
        checks++; if (v_data[n0+1] !== 8'h3C) begin errors++; $display("FAIL frm_next_data got %h exp 3c", v_data[n0+1]); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL frm_next_fe got %b exp 0", bus.framing_error); end
    endtask

    task automatic test_glitch();
        int  n0;
        logic seen;
        n0     = vcount;
        seen   = 1'b0;
        bus.rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b exp 1", seen); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", bus.busy); end
        checks++; if (vcount !== n0) begin errors++; $display("FAIL glitch_count got %0d exp 0", vcount - n0); end
        checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_data got %h exp 3c", bus.rx_data); end
        checks++; if (bus.framing_error !== 1'b0 || bus.parity_error !== 1'b0) begin
            errors++; $display("FAIL glitch_flags got %b%b exp 00", bus.parity_error, bus.framing_error);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        logic [7:0] d;
        d  = 8'h5A;
        n0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        bus.rx = d[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", bus.rx_valid); end
        checks++; if (bus.parity_error !== 1'b0 || bus.framing_error !== 1'b0) begin
            errors++; $display("FAIL rmid_flags got %b%b exp 00", bus.parity_error, bus.framing_error);
        end
        idle(2 * CPB);
        checks++; if (vcount !== n0) begin errors++; $display("FAIL rmid_no_valid got %0d exp 0", vcount - n0); end
        send_frame(8'hF0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL rmid_next_count got %0d exp 1", vcount - n0); end
        checks++; if (v_data[n0] !== 8'hF0) begin errors++; $display("FAIL rmid_next_data got %h exp f0", v_data[n0]); end
        checks++; if (v_pe[n0] !== 1'b0 || v_fe[n0] !== 1'b0) begin
            errors++; $display("FAIL rmid_next_flags got %b%b exp 00", v_pe[n0], v_fe[n0]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = vcount;
        send_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", vcount - n0); end
        checks++; if (v_data[n0] !== 8'h81) begin errors++; $display("FAIL b2b_data0 got %h exp 81", v_data[n0]); end
        checks++; if (v_data[n0+1] !== 8'h7E) begin errors++; $display("FAIL b2b_data1 got %h exp 7e", v_data[n0+1]); end
        checks++; if (v_cyc[n0+1] - v_cyc[n0] !== FRAME_BITS * CPB) begin
            errors++; $display("FAIL b2b_spacing got %0d exp %0d", v_cyc[n0+1] - v_cyc[n0], FRAME_BITS * CPB);
        end
        checks++; if (v_pe[n0] !== 1'b0 || v_pe[n0+1] !== 1'b0) begin
            errors++; $display("FAIL b2b_pe got %b%b exp 00", v_pe[n0], v_pe[n0+1]);
        end
        checks++; if (v_fe[n0] !== 1'b0 || v_fe[n0+1] !== 1'b0) begin
            errors++; $display("FAIL b2b_fe got %b%b exp 00", v_fe[n0], v_fe[n0+1]);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
